// File: rtl/clkcheck.sv
// Divided-clock health monitor: synchronizes clk into the CLK domain, strobes its edges,
// measures period/high time and tracks lock with a sticky fault flag.
module clkcheck #(
    parameter int unsigned CLKDIV    = 4,
    parameter int unsigned LOCKCOUNT = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       clk,
    output logic       rise,
    output logic       fall,
    output logic [3:0] period,
    output logic [3:0] high,
    output logic       locked,
    output logic       error
);

    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] EXP_PER  = CW'(CLKDIV);
    localparam logic [CW-1:0] EXP_HIGH = CW'(CLKDIV / 2);
    localparam logic [CW-1:0] LOCK_N   = CW'(LOCKCOUNT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          sync_q, s_q, sd_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] gcnt_q, gcnt_d;
    logic          hvalid_q, hvalid_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] period_q, period_d;
    logic [CW-1:0] high_q, high_d;
    logic          locked_q, locked_d;
    logic          error_q, error_d;

    logic          e_r_c, e_f_c, good_c, sat_c;

    assign e_r_c  = s_q & ~sd_q;
    assign e_f_c  = ~s_q & sd_q;
    assign sat_c  = (cnt_q == CNT_MAX);
    assign good_c = (cnt_q == EXP_PER) && hvalid_q && (high_q == EXP_HIGH);

    // Next-state: counter, measurements and lock FSM; an edge always beats a timeout.
    always_comb begin
        state_d  = state_q;
        gcnt_d   = gcnt_q;
        hvalid_d = hvalid_q;
        period_d = period_q;
        high_d   = high_q;
        error_d  = error_q;
        rise_d   = e_r_c;
        fall_d   = e_f_c;

        if (e_r_c) begin
            cnt_d = CW'(1);
        end else if (sat_c) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        if (e_r_c) begin
            period_d = cnt_q;
            hvalid_d = 1'b0;
        end
        if (e_f_c) begin
            high_d   = cnt_q;
            hvalid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (e_r_c) begin
                    state_d = ACQ;
                    gcnt_d  = '0;
                end
            end
            ACQ: begin
                if (e_r_c) begin
                    if (good_c) begin
                        gcnt_d = gcnt_q + CW'(1);
                        if (gcnt_q + CW'(1) == LOCK_N) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        gcnt_d = '0;
                    end
                end else if (sat_c) begin
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                if (e_r_c) begin
                    if (!good_c) begin
                        state_d = ACQ;
                        gcnt_d  = '0;
                        error_d = 1'b1;
                    end
                end else if (sat_c) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gcnt_d  = '0;
            end
        endcase

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            sync_q   <= 1'b0;
            s_q      <= 1'b0;
            sd_q     <= 1'b0;
            cnt_q    <= '0;
            gcnt_q   <= '0;
            hvalid_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            period_q <= '0;
            high_q   <= '0;
            locked_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= clk;
            s_q      <= sync_q;
            sd_q     <= s_q;
            cnt_q    <= cnt_d;
            gcnt_q   <= gcnt_d;
            hvalid_q <= hvalid_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            period_q <= period_d;
            high_q   <= high_d;
            locked_q <= locked_d;
            error_q  <= error_d;
        end
    end

    assign rise   = rise_q;
    assign fall   = fall_q;
    assign period = period_q;
    assign high   = high_q;
    assign locked = locked_q;
    assign error  = error_q;

endmodule

// File: tb/tb_clkcheck.sv
// Directed bench for clkcheck: two instances (ratio 4 and 5) watch the same driven clk.
module tb_clkcheck;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       clk;

    logic       rise4, fall4, locked4, error4;
    logic [3:0] period4, high4;
    logic       rise5, fall5, locked5, error5;
    logic [3:0] period5, high5;

    int checks = 0;
    int errors = 0;

    clkcheck #(.CLKDIV(4), .LOCKCOUNT(4)) u_dut4 (
        .CLK(CLK), .RESET(RESET), .clk(clk),
        .rise(rise4), .fall(fall4), .period(period4), .high(high4),
        .locked(locked4), .error(error4)
    );

    clkcheck #(.CLKDIV(5), .LOCKCOUNT(4)) u_dut5 (
        .CLK(CLK), .RESET(RESET), .clk(clk),
        .rise(rise5), .fall(fall5), .period(period5), .high(high5),
        .locked(locked5), .error(error5)
    );

    always #5 CLK = ~CLK;

    // Edge-event bookkeeping sampled on the inactive edge.
    int cyc = 0;
    int rc4 = 0, rc5 = 0;
    int lock_rc4 = -1, lock_rc5 = -1;
    int unlock_rc4 = -1, err_rc4 = -1;
    int lastr_cyc4 = -1, unlock_cyc4 = -1;
    int dbl4 = 0;
    logic lk4_q = 1'b0, lk5_q = 1'b0, er4_q = 1'b0, r4_q = 1'b0, f4_q = 1'b0;

    always @(negedge CLK) begin
        cyc <= cyc + 1;
        rc4 <= rc4 + int'(rise4);
        rc5 <= rc5 + int'(rise5);
        if (rise4) lastr_cyc4 <= cyc;
        if (locked4 && !lk4_q) lock_rc4 <= rc4 + int'(rise4);
        if (locked5 && !lk5_q) lock_rc5 <= rc5 + int'(rise5);
        if (!locked4 && lk4_q) begin
            unlock_rc4  <= rc4 + int'(rise4);
            unlock_cyc4 <= cyc;
        end
        if (error4 && !er4_q) err_rc4 <= rc4 + int'(rise4);
        if ((rise4 && r4_q) || (fall4 && f4_q)) dbl4 <= dbl4 + 1;
        lk4_q <= locked4;
        lk5_q <= locked5;
        er4_q <= error4;
        r4_q  <= rise4;
        f4_q  <= fall4;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        repeat (n) begin
            clk = 1'b1;
            repeat (hi) tick();
            clk = 1'b0;
            repeat (lo) tick();
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        clk   = 1'b0;
        repeat (3) tick();
        RESET = 1'b0;
        tick();
    endtask

    int base;

    initial begin
        RESET = 1'b1;
        clk   = 1'b0;
        repeat (2) tick();
        chk("rst_rise",   32'(rise4),   0);
        chk("rst_fall",   32'(fall4),   0);
        chk("rst_period", 32'(period4), 0);
        chk("rst_high",   32'(high4),   0);
        chk("rst_locked", 32'(locked4), 0);
        chk("rst_error",  32'(error4),  0);
        RESET = 1'b0;
        tick();

        // Source divides by 6 while the checker expects 4.
        wave(3, 3, 8);
        chk("wrong_period", 32'(period4), 6);
        chk("wrong_high",   32'(high4),   3);
        chk("wrong_locked", 32'(locked4), 0);
        chk("wrong_error",  32'(error4),  0);
        chk("wrong5_locked", 32'(locked5), 0);
        repeat (25) tick();
        chk("acq_timeout_error", 32'(error4), 0);

        // Odd ratio: 2 high, 3 low.
        do_reset();
        base = rc5;
        wave(2, 3, 8);
        chk("odd_period", 32'(period5), 5);
        chk("odd_high",   32'(high5),   2);
        chk("odd_locked", 32'(locked5), 1);
        chk("odd_lock_rise", 32'(lock_rc5 - base), 5);
        chk("odd_error",  32'(error5),  0);

        // Nominal ratio 4.
        do_reset();
        base = rc4;
        wave(2, 2, 8);
        chk("nom_period", 32'(period4), 4);
        chk("nom_high",   32'(high4),   2);
        chk("nom_locked", 32'(locked4), 1);
        chk("nom_lock_rise", 32'(lock_rc4 - base), 5);
        chk("nom_rises",  32'(rc4 - base), 8);
        chk("nom_error",  32'(error4),  0);
        chk("nom5_locked", 32'(locked5), 0);

        // Extra one-cycle high pulse inside a low phase while locked.
        base = rc4;
        clk = 1'b1; repeat (2) tick();
        clk = 1'b0; tick();
        clk = 1'b1; tick();
        clk = 1'b0; tick();
        wave(2, 2, 8);
        chk("glitch_unlock_rise", 32'(unlock_rc4 - base), 2);
        chk("glitch_err_rise",    32'(err_rc4 - base),    2);
        chk("glitch_relock_rise", 32'(lock_rc4 - base),   7);
        chk("glitch_locked", 32'(locked4), 1);
        chk("glitch_error",  32'(error4),  1);

        // Asynchronous reset between clock edges.
        @(posedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        chk("arst_rise",   32'(rise4),   0);
        chk("arst_fall",   32'(fall4),   0);
        chk("arst_period", 32'(period4), 0);
        chk("arst_high",   32'(high4),   0);
        chk("arst_locked", 32'(locked4), 0);
        chk("arst_error",  32'(error4),  0);
        repeat (2) tick();
        RESET = 1'b0;
        tick();
        base = rc4;
        wave(2, 2, 8);
        chk("arst_relock_rise", 32'(lock_rc4 - base), 5);
        chk("arst_relock_error", 32'(error4), 0);

        // Stall while locked, then restart.
        repeat (25) tick();
        chk("stall_latency", 32'(unlock_cyc4 - lastr_cyc4), 15);
        chk("stall_locked",  32'(locked4), 0);
        chk("stall_error",   32'(error4),  1);
        base = rc4;
        wave(2, 2, 8);
        chk("restart_lock_rise", 32'(lock_rc4 - base), 5);
        chk("restart_locked", 32'(locked4), 1);
        chk("restart_error",  32'(error4),  1);
        chk("strobe_width",   32'(dbl4),    0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clkcheck.md
# clkcheck

Receive-side companion to the clock divider: it monitors a divided clock, nominally generated from the same fast clock, and checks that it really toggles at CLK/CLKDIV. It synchronizes the divided clock into the CLK domain, emits one-cycle edge strobes, and measures period and high time in CLK cycles. It declares lock after a run of correct periods and raises a sticky error when a locked clock misbehaves or stops. It sits next to each divided-clock consumer as a bring-up and health monitor, and its edge strobes serve as clock enables for CLK-domain logic.

## Interface
- CLKDIV, 4: expected divide ratio, legal range 2..8. Expected high time is CLKDIV/2 (integer division); expected low time is the remainder.
- LOCKCOUNT, 4: number of consecutive good periods required to lock, legal range 1..15.

Ports (one clock; reset is asynchronous and active-high):
- CLK  in  1  fast system clock; all state is on posedge CLK.
- RESET  in  1  asynchronous, active-high reset.
- clk  in  1  divided clock under test, treated as asynchronous.
- rise  out  1  one-CLK strobe for each synchronized rising edge of clk.
- fall  out  1  one-CLK strobe for each synchronized falling edge of clk.
- period  out  4  last measured period in CLK cycles, saturating at 15.
- high  out  4  last measured high time in CLK cycles, saturating at 15.
- locked  out  1  high while in state LOCKED.
- error  out  1  sticky fault flag; cleared only by RESET.

## Operation
- Synchronizer and edge detect:
  - clk passes through 2 flops to give s; s_d is s delayed by one cycle.
  - Internal rise edge e_r = s & ~s_d; internal fall edge e_f = ~s & s_d.
- Counter cnt (4 bits):
  - Loads 1 on e_r.
  - Otherwise increments, saturating at 15.
- Measurements:
  - On e_r: period <= cnt.
  - On e_f: high <= cnt, and hvalid is set.
  - hvalid is cleared on e_r.
- A period is good only when, at e_r: cnt == CLKDIV, hvalid == 1, and the latched high == CLKDIV/2.
- Good-period counter gcnt (4 bits) counts consecutive good periods.
- States:
  - IDLE:
    - On e_r: go to ACQ, gcnt <= 0. This first period is not evaluated.
    - cnt timeout is ignored in IDLE.
  - ACQ:
    - On e_r with a good period: gcnt++. When gcnt+1 == LOCKCOUNT, go to LOCKED.
    - On e_r with a bad period: gcnt <= 0, stay in ACQ. error is not set.
    - If cnt == 15 and no e_r: go to IDLE, error is not set.
  - LOCKED:
    - On e_r with a bad period: go to ACQ, gcnt <= 0, error <= 1.
    - If cnt == 15 and no e_r: go to IDLE, error <= 1.
- locked is 1 exactly when the state is LOCKED.
- Simultaneous e_r and saturation at 15: e_r wins. The period is evaluated with cnt = 15, which is bad for every legal CLKDIV.
- RESET, whether asserted idle or mid-operation, forces the following immediately, with no clock required:
  - state IDLE; cnt, gcnt, hvalid and both synchronizer flops cleared.
  - All outputs 0: rise, fall, period, high, locked, error.

## Timing
- Edge strobes:
  - If clk changes after CLK edge k, s changes at edge k+2.
  - rise or fall is registered high for exactly one cycle, from edge k+3.
  - period, high, state, locked and error update at that same edge k+3.
- Lock latency:
  - locked rises at the (LOCKCOUNT+1)-th detected rising edge after IDLE.
  - That edge must end an unbroken run of LOCKCOUNT good periods.
- Loss latency:
  - locked falls and error rises at the edge where cnt would exceed 15, i.e. 15 CLK cycles after the last e_r.
  - For a bad period while locked, they update at the offending e_r.
- There is no back-pressure and no handshake. The strobes are never held for more than one cycle.

## Test plan
- Nominal lock:
  - Stimulus: clkdiv with CLKDIV=4 drives clk; clkcheck uses CLKDIV=4, LOCKCOUNT=4.
  - Required: rise every 4 cycles, period=4, high=2, locked=1 at the 5th rise, error=0.
- Odd ratio:
  - Stimulus: CLKDIV=5 on both the source and clkcheck.
  - Required: period=5, high=2, locks at the 5th rise.
- Wrong divisor:
  - Stimulus: source divides by 6; clkcheck expects 4.
  - Required: period=6, high=3, locked stays 0, error stays 0.
- Stall while locked:
  - Stimulus: hold clk low after lock.
  - Required: 15 cycles after the last e_r, locked=0, error=1, state IDLE.
  - Then restart clk: relocks at the 5th rise, error remains 1.
- Glitch while locked:
  - Stimulus: insert one extra 1-cycle high pulse.
  - Required: locked=0 and error=1 at the glitch rise; relocks after 4 good periods.
- Reset mid-lock:
  - Stimulus: assert RESET asynchronously between CLK edges.
  - Required: all outputs 0 immediately; full relock sequence after release.
